imem_boot_ctrl: RTL

- Boot-time loader and sequencer for the pipelined RISC-V core.
- Receives a byte stream on a valid/ready port and packs it into 32-bit little-endian words.
- Writes the words into instruction memory through the I-mem write port.
- Holds the core in reset until the image is complete, then releases it. This replaces simulation-only memory preload.

---
 rtl/boot_pkg.sv | 49 ++++
 rtl/boot_word_packer.sv | 35 +++
 rtl/imem_boot_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// Shared types for the instruction-memory boot loader: FSM states and the
// per-state control outputs.
package boot_pkg;

    localparam int HDR_BYTES  = 4;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    typedef struct packed {
        logic s_ready;
        logic busy;
        logic done;
        logic err;
        logic core_rstn;
        logic imem_we;
    } ctrl_t;

    // Output values that hold for the whole time the FSM sits in state s.
    function automatic ctrl_t state_ctrl(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            HDR, DATA: begin
                c.s_ready = 1'b1;
                c.busy    = 1'b1;
            end
            WRITE: begin
                c.busy    = 1'b1;
                c.imem_we = 1'b1;
            end
            DONE: begin
                c.done      = 1'b1;
                c.core_rstn = 1'b1;
            end
            ERR:     c.err = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/boot_word_packer.sv
// Packs a byte stream into 32-bit little-endian words; the header count and
// the data words both go through this one packer.
module boot_word_packer
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        byte_en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_full_o
);

    logic [1:0]  cnt_q;
    logic [31:0] word_q;

    assign word_full_o = byte_en_i && (cnt_q == 2'(WORD_BYTES - 1));
    assign word_o      = word_q;

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else if (clear_i) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else if (byte_en_i) begin
            word_q[8*cnt_q +: 8] <= byte_i;
            cnt_q                <= cnt_q + 2'd1;
        end
    end

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot loader: reads a word-count header and that many words from a byte
// stream, writes them to I-mem, then releases the core from reset.
module imem_boot_ctrl
    import boot_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rstn,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            state_q, state_d;
    ctrl_t             ctrl_q;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic [ADDR_W-1:0] last_idx_q, last_idx_d;
    logic              clear;
    logic              byte_en;
    logic              word_full;
    logic [31:0]       pk_word;
    logic [31:0]       hdr_count;

    assign byte_en = s_valid & ctrl_q.s_ready;
    // Complete header value on the edge its last byte arrives.
    assign hdr_count = {s_data, pk_word[23:0]};

    boot_word_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (clear),
        .byte_en_i   (byte_en),
        .byte_i      (s_data),
        .word_o      (pk_word),
        .word_full_o (word_full)
    );

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        last_idx_d = last_idx_q;
        clear      = 1'b0;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d    = HDR;
                    word_idx_d = '0;
                    clear      = 1'b1;
                end
            end
            HDR: begin
                if (word_full) begin
                    if (hdr_count == 32'd0) begin
                        state_d = DONE;
                    end else if (hdr_count > 32'(MEM_DEPTH)) begin
                        state_d = ERR;
                    end else begin
                        last_idx_d = ADDR_W'(hdr_count - 32'd1);
                        state_d    = DATA;
                    end
                end
            end
            DATA: begin
                if (word_full) state_d = WRITE;
            end
            WRITE: begin
                if (word_idx_q == last_idx_q) begin
                    state_d = DONE;
                end else begin
                    word_idx_d = word_idx_q + ADDR_W'(1);
                    state_d    = DATA;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ctrl_q     <= '0;
            word_idx_q <= '0;
            last_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= state_ctrl(state_d);
            word_idx_q <= word_idx_d;
            last_idx_q <= last_idx_d;
        end
    end

    assign s_ready    = ctrl_q.s_ready;
    assign busy       = ctrl_q.busy;
    assign done       = ctrl_q.done;
    assign err        = ctrl_q.err;
    assign core_rstn  = ctrl_q.core_rstn;
    assign imem_we    = ctrl_q.imem_we;
    assign imem_addr  = word_idx_q;
    assign imem_wdata = pk_word;

endmodule
